// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code decoder: FSM state encoding and default width.
package gray_pkg;

  localparam int CBITS_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary conversion (running XOR from the MSB down).
module gray2bin #(
  parameter int CBITS = gray_pkg::CBITS_DEFAULT
) (
  input  logic [CBITS-1:0] gray_i,
  output logic [CBITS-1:0] bin_o
);

  always_comb begin
    logic acc;
    acc   = 1'b0;
    bin_o = '0;
    for (int i = CBITS - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Decodes gray counter samples, tracks that they only hold or advance by one,
// and counts (saturating) every sample that breaks the sequence.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int CBITS = CBITS_DEFAULT,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_vld,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             zero,
  output logic             wrap,
  output logic             step_err,
  output logic             locked,
  output logic [ERRW-1:0]  err_cnt
);

  state_t           state_q, state_d;
  logic [CBITS-1:0] bin_q, bin_d;
  logic             vld_q, vld_d;
  logic             zero_q, zero_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [ERRW-1:0]  cnt_q, cnt_d;

  logic [CBITS-1:0] decoded;
  logic [CBITS-1:0] succ;

  gray2bin #(.CBITS(CBITS)) u_gray2bin (
    .gray_i (gray_in),
    .bin_o  (decoded)
  );

  // Sized add so the successor wraps modulo 2^CBITS.
  assign succ = bin_q + CBITS'(1);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    vld_d   = 1'b0;
    zero_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (gray_vld) begin
      case (state_q)
        IDLE, FAULT: begin
          bin_d   = decoded;
          vld_d   = 1'b1;
          state_d = TRACK;
        end
        TRACK: begin
          if (decoded == bin_q) begin
            vld_d = 1'b1;
          end else if (decoded == succ) begin
            bin_d  = decoded;
            vld_d  = 1'b1;
            wrap_d = (bin_q == '1);
            zero_d = (decoded == '0);
          end else begin
            err_d   = 1'b1;
            state_d = FAULT;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + ERRW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bin_out  = bin_q;
  assign bin_vld  = vld_q;
  assign zero     = zero_q;
  assign wrap     = wrap_q;
  assign step_err = err_q;
  assign locked   = (state_q == TRACK);
  assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed plus randomized bench for gray_decoder; expected values come from a
// value-level model that thinks in binary counts, not in the decoder's states.
module tb_gray_decoder;

  localparam int CBITS = 9;
  localparam int ERRW  = 8;
  localparam int MODV  = 1 << CBITS;
  localparam int CMAX  = (1 << ERRW) - 1;

  logic             clk;
  logic             rst_n;
  logic [CBITS-1:0] gray_in;
  logic             gray_vld;
  logic [CBITS-1:0] bin_out;
  logic             bin_vld;
  logic             zero;
  logic             wrap;
  logic             step_err;
  logic             locked;
  logic [ERRW-1:0]  err_cnt;

  int nAsserts;
  int nFails;

  // Reference model: a sample is either accepted as a new reference, repeated,
  // incremented by one (mod 512), or rejected.
  bit haveRef;
  int expBin;
  int expCnt;
  bit expVld, expZero, expWrap, expErr;

  gray_decoder #(.CBITS(CBITS), .ERRW(ERRW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .gray_vld (gray_vld),
    .bin_out  (bin_out),
    .bin_vld  (bin_vld),
    .zero     (zero),
    .wrap     (wrap),
    .step_err (step_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CBITS-1:0] toGray(input int b);
    int g;
    g = b ^ (b >> 1);
    return g[CBITS-1:0];
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    assert (got === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("bin_out",  32'(bin_out),  32'(expBin));
    checkEq("bin_vld",  32'(bin_vld),  32'(expVld));
    checkEq("zero",     32'(zero),     32'(expZero));
    checkEq("wrap",     32'(wrap),     32'(expWrap));
    checkEq("step_err", 32'(step_err), 32'(expErr));
    checkEq("locked",   32'(locked),   32'(haveRef));
    checkEq("err_cnt",  32'(err_cnt),  32'(expCnt));
  endtask

  task automatic modelReset();
    haveRef = 1'b0;
    expBin  = 0;
    expCnt  = 0;
    expVld  = 1'b0;
    expZero = 1'b0;
    expWrap = 1'b0;
    expErr  = 1'b0;
  endtask

  // Drive one cycle of input, let the edge happen, then predict and compare.
  task automatic applyStimulus(input bit vld, input int b);
    gray_in  = toGray(b);
    gray_vld = vld;
    @(posedge clk);
    #1;
    expVld  = 1'b0;
    expZero = 1'b0;
    expWrap = 1'b0;
    expErr  = 1'b0;
    if (vld) begin
      if (!haveRef) begin
        expBin  = b;
        expVld  = 1'b1;
        haveRef = 1'b1;
      end else if (b == expBin) begin
        expVld = 1'b1;
      end else if (b == (expBin + 1) % MODV) begin
        expWrap = (expBin == MODV - 1);
        expZero = (b == 0);
        expBin  = b;
        expVld  = 1'b1;
      end else begin
        expErr  = 1'b1;
        haveRef = 1'b0;
        if (expCnt < CMAX) expCnt++;
      end
    end
    gray_vld = 1'b0;
    checkOutput();
  endtask

  initial begin
    int c;
    int b;
    nAsserts = 0;
    nFails   = 0;
    rst_n    = 1'b0;
    gray_in  = '0;
    gray_vld = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();

    // Lock on 0, then count through the full range and wrap back to 0.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 0);
    for (int i = 1; i < MODV; i++) applyStimulus(1'b1, i);
    applyStimulus(1'b1, 0);
    checkEq("wrap_at_0", 32'(wrap), 32'd1);

    // Skip from 0 to 2 is rejected; 3 then re-locks.
    applyStimulus(1'b1, 2);
    applyStimulus(1'b1, 3);

    // 255 is illegal after 3; it then re-locks and holds for three samples.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 255);

    // Idle cycles with noise on gray_in must not disturb anything.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom_range(0, MODV - 1));

    // Random mix biased towards legal hold/advance steps.
    for (int i = 0; i < 300; i++) begin
      c = $urandom_range(0, 7);
      if (c < 4)       b = (expBin + 1) % MODV;
      else if (c < 6)  b = expBin;
      else             b = $urandom_range(0, MODV - 1);
      applyStimulus($urandom_range(0, 5) != 0, b);
    end

    // Make sure the decoder is tracking, then reset it between clock edges.
    applyStimulus(1'b1, 100);
    applyStimulus(1'b1, 101);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 7);
    checkEq("lock_after_reset", 32'(locked), 32'd1);

    // Alternate rejected jumps and re-locks until the error counter saturates.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 5);
      applyStimulus(1'b1, 0);
    end
    checkEq("err_cnt_sat", 32'(err_cnt), 32'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/gray_decoder.md
GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 Parameter: CBITS, default 9, width of the gray-coded input and binary output.
REQ-002 Parameter: ERRW, default 8, width of the saturating error counter.
REQ-003 Port: clk  input  1  single clock, all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: gray_in  input  CBITS  gray-coded counter sample, produced by the team's gray counter.
REQ-006 Port: gray_vld  input  1  high for one cycle per gray_in sample to be consumed.
REQ-007 Port: bin_out  output  CBITS  registered binary value decoded from the last accepted sample.
REQ-008 Port: bin_vld  output  1  one-cycle pulse, bin_out updated this cycle.
REQ-009 Port: zero  output  1  one-cycle pulse with bin_vld when the decoded value is 0 and the state is TRACK.
REQ-010 Port: wrap  output  1  one-cycle pulse with bin_vld when the decoded value goes from 2^CBITS-1 to 0.
REQ-011 Port: step_err  output  1  one-cycle pulse, sample neither equal to nor the successor of the previous sample.
REQ-012 Port: locked  output  1  level, high while the state is TRACK.
REQ-013 Port: err_cnt  output  ERRW  saturating count of step_err pulses.

Function
REQ-014 Decode: bin[CBITS-1] = g[CBITS-1]; bin[i] = bin[i+1] XOR g[i], for i = CBITS-2 down to 0.
REQ-015 Latency: a sample with gray_vld high in cycle N gives bin_out, bin_vld and its flags in cycle N+1; no other latency is allowed.
REQ-016 The FSM has three states: IDLE (no reference), TRACK (locked), FAULT (last sample rejected).
REQ-017 IDLE + gray_vld: the sample is accepted as the reference; bin_out = decode; bin_vld = 1; next state TRACK; no step_err.
REQ-018 TRACK + gray_vld, decode equal to previous: hold; bin_vld = 1; bin_out unchanged; zero and wrap stay low.
REQ-019 TRACK + gray_vld, decode = previous+1 mod 2^CBITS: advance; bin_vld = 1; wrap is high if the previous value was 2^CBITS-1.
REQ-020 TRACK + gray_vld, any other value: step_err = 1; bin_vld = 0; bin_out holds the old value; next state FAULT.
REQ-021 FAULT + gray_vld: re-lock; the sample becomes the new reference; bin_vld = 1; no wrap or step_err; next state TRACK.
REQ-022 gray_vld low: no state change; all pulse outputs low.
REQ-023 err_cnt increments on each step_err and stops at 2^ERRW-1; it never wraps.
REQ-024 Successor arithmetic is modulo 2^CBITS; the carry out is dropped.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, bin_out 0, err_cnt 0, and bin_vld, zero, wrap, step_err, locked all 0.
REQ-026 Reset during TRACK or FAULT discards the reference; the first sample after reset follows REQ-017.
REQ-027 A gray_vld in the first posedge after rst_n deasserts is accepted normally.

Structure
REQ-028 Shared package gray_pkg holds the state enum (IDLE, TRACK, FAULT) and the CBITS default constant.
REQ-029 One combinational sub-module gray2bin (parameter CBITS) does the REQ-014 decode; the FSM, flags and counter live in gray_decoder.

Verification
REQ-030 Bench with CBITS = 9 runs all scenarios below.
REQ-031 Reset, then gray_in 0x000 with gray_vld -> next cycle bin_out 0, bin_vld 1, locked 1, zero 0 (lock sample).
REQ-032 Feed gray(0..511) then gray(0), one per cycle -> bin_out counts 0..511, 0; step_err never fires.
REQ-033 In the same run, sample 0x100 (511) then 0x000 -> bin_out 0 with both wrap and zero high.
REQ-034 Locked at 0x000, feed 0x003 (bin 2) -> step_err 1, bin_vld 0, bin_out 0, err_cnt 1. Next feed 0x002 (bin 3) -> re-lock, bin_out 3, locked 1.
REQ-035 Repeat 0x080 (bin 255) for three samples -> bin_vld each cycle, bin_out 255, no step_err.
REQ-036 Deassert rst_n mid-TRACK -> all outputs 0 right away with no clock edge needed. Force 260 illegal steps -> err_cnt stops at 255.
